demux_2out_nbit: RTL and testbench

Registered 1-to-2 N-bit demultiplexer, the receive-side counterpart of the 2-input N-bit mux. It accepts a time-multiplexed word stream tagged with a select bit and steers each word into one of two single-entry output slots. Each slot has its own valid/ready handshake toward a downstream consumer. Per-channel saturating word counters support debug and the mux/demux loopback benches.

---
 rtl/demux_2out_nbit_pkg.sv | 20 ++
 rtl/demux_2out_nbit_if.sv | 35 +++
 rtl/demux_2out_nbit_slot.sv | 66 ++++++
 rtl/demux_2out_nbit.sv | 94 +++++++++
 tb/tb_demux_2out_nbit.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/demux_2out_nbit_pkg.sv
// Shared definitions for the 1-to-2 demux: channel encodings, default widths, slot states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package demux_2out_nbit_pkg;

  // Value of in_sel that steers a word to each channel
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // Default data width and per-channel counter width
  localparam int DEF_N     = 2;
  localparam int DEF_CNT_W = 4;

  // Single-entry slot occupancy
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_2out_nbit_if.sv
// Bundle of the demux input stream, both output channels and the debug counters.
// Latency: n/a (wiring only).
// Backpressure: in_ready toward the sender, z0_ready/z1_ready from the consumers.
interface demux_2out_nbit_if import demux_2out_nbit_pkg::*; #(
  parameter int N     = DEF_N,
  parameter int CNT_W = DEF_CNT_W
);

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_sel;
  logic [N-1:0]     z0;
  logic             z0_valid;
  logic             z0_ready;
  logic [N-1:0]     z1;
  logic             z1_valid;
  logic             z1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic             cnt_clr;

  // Environment side: sender, both consumers and the counter-clear source
  modport master (
    output in_valid, in_data, in_sel, z0_ready, z1_ready, cnt_clr,
    input  in_ready, z0, z0_valid, z1, z1_valid, cnt0, cnt1
  );

  // Demux side
  modport slave (
    input  in_valid, in_data, in_sel, z0_ready, z1_ready, cnt_clr,
    output in_ready, z0, z0_valid, z1, z1_valid, cnt0, cnt1
  );

endinterface

// File: rtl/demux_2out_nbit_slot.sv
// Single-entry output slot: one word register plus a valid flag.
// Latency: a loaded word is visible on o_data/o_valid one clk after i_load.
// Backpressure: o_take is high when empty or being drained this cycle (pass-through ready).
module demux_slot import demux_2out_nbit_pkg::*; #(
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [N-1:0] i_data,
  input  logic         i_ready,
  output logic [N-1:0] o_data,
  output logic         o_valid,
  output logic         o_take
);

  slot_state_e  r_state;
  slot_state_e  w_next;
  logic [N-1:0] r_data;

  // State register; reset drops any held word immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SLOT_EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: a load always leaves the slot full, a drain without load empties it
  always_comb begin
    w_next = r_state;
    case (r_state)
      SLOT_EMPTY: begin
        if (i_load) begin
          w_next = SLOT_FULL;
        end
      end
      SLOT_FULL: begin
        if (i_load) begin
          w_next = SLOT_FULL;
        end else if (i_ready) begin
          w_next = SLOT_EMPTY;
        end
      end
      default: w_next = SLOT_EMPTY;
    endcase
  end

  // Word register; keeps its last value after a drain, only a load or reset changes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  // Outputs: valid follows occupancy, take allows same-cycle drain and refill
  always_comb begin
    o_data  = r_data;
    o_valid = (r_state == SLOT_FULL);
    o_take  = (r_state == SLOT_EMPTY) || i_ready;
  end

endmodule

// File: rtl/demux_2out_nbit.sv
// Registered 1-to-2 N-bit demux: steers each tagged input word into one of two single-entry slots.
// Latency: 1 clk from accept to zK/zK_valid; 1 word/clk sustained when the consumer holds ready.
// Backpressure: in_ready mirrors the selected slot's take condition; a stalled slot blocks only while selected.
module demux_2out_nbit import demux_2out_nbit_pkg::*; #(
  parameter int N     = DEF_N,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  demux_2out_nbit_if.slave   bus
);

  logic             w_take0;
  logic             w_take1;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_load0;
  logic             w_load1;
  logic [N-1:0]     w_z0;
  logic [N-1:0]     w_z1;
  logic             w_z0_valid;
  logic             w_z1_valid;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Routing: in_ready depends only on the selected slot, never on in_valid
  always_comb begin
    w_in_ready = (bus.in_sel == CH1) ? w_take1 : w_take0;
    w_accept   = bus.in_valid && w_in_ready;
    w_load0    = w_accept && (bus.in_sel == CH0);
    w_load1    = w_accept && (bus.in_sel == CH1);
  end

  demux_slot #(.N(N)) u_slot0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load0),
    .i_data  (bus.in_data),
    .i_ready (bus.z0_ready),
    .o_data  (w_z0),
    .o_valid (w_z0_valid),
    .o_take  (w_take0)
  );

  demux_slot #(.N(N)) u_slot1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load1),
    .i_data  (bus.in_data),
    .i_ready (bus.z1_ready),
    .o_data  (w_z1),
    .o_valid (w_z1_valid),
    .o_take  (w_take1)
  );

  // Channel 0 accepted-word counter; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
    end else if (bus.cnt_clr) begin
      r_cnt0 <= '0;
    end else if (w_load0) begin
      r_cnt0 <= sat_inc(r_cnt0);
    end
  end

  // Channel 1 accepted-word counter; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt1 <= '0;
    end else if (bus.cnt_clr) begin
      r_cnt1 <= '0;
    end else if (w_load1) begin
      r_cnt1 <= sat_inc(r_cnt1);
    end
  end

  // Drive the interface outputs
  always_comb begin
    bus.in_ready = w_in_ready;
    bus.z0       = w_z0;
    bus.z0_valid = w_z0_valid;
    bus.z1       = w_z1;
    bus.z1_valid = w_z1_valid;
    bus.cnt0     = r_cnt0;
    bus.cnt1     = r_cnt1;
  end

endmodule

// File: tb/tb_demux_2out_nbit.sv
// Directed bench for demux_2out_nbit with N=2, CNT_W=4.
// Inputs change 1 time unit after the rising edge; in_ready is sampled on the falling edge,
// registered outputs 1 time unit after the rising edge.
module tb_demux_2out_nbit;
  import demux_2out_nbit_pkg::*;

  localparam int N     = 2;
  localparam int CNT_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  demux_2out_nbit_if #(.N(N), .CNT_W(CNT_W)) bus ();

  demux_2out_nbit #(.N(N), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec   = 0;
  int n_bad   = 0;
  int n_proto = 0;

  // One cycle of stimulus and the expected result: in_ready before the edge, state after it
  typedef struct {
    logic             v;
    logic             s;
    logic [N-1:0]     d;
    logic             r0;
    logic             r1;
    logic             clr;
    logic             e_ir;
    logic [N-1:0]     e_z0;
    logic             e_v0;
    logic [N-1:0]     e_z1;
    logic             e_v1;
    logic [CNT_W-1:0] e_c0;
    logic [CNT_W-1:0] e_c1;
  } vec_t;

  localparam int NROWS = 19;
  vec_t tbl [NROWS];

  function automatic vec_t mk(
    input logic v, input logic s, input logic [N-1:0] d,
    input logic r0, input logic r1, input logic clr,
    input logic e_ir, input logic [N-1:0] e_z0, input logic e_v0,
    input logic [N-1:0] e_z1, input logic e_v1,
    input logic [CNT_W-1:0] e_c0, input logic [CNT_W-1:0] e_c1);
    vec_t r;
    r.v = v; r.s = s; r.d = d; r.r0 = r0; r.r1 = r1; r.clr = clr;
    r.e_ir = e_ir; r.e_z0 = e_z0; r.e_v0 = e_v0; r.e_z1 = e_z1; r.e_v1 = e_v1;
    r.e_c0 = e_c0; r.e_c1 = e_c1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [N-1:0] d,
                       input logic r0, input logic r1, input logic clr);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
    bus.z0_ready = r0;
    bus.z1_ready = r1;
    bus.cnt_clr  = clr;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Sender rule monitor: a word still pending at one falling edge must be presented unchanged at the next
  logic         pend = 1'b0;
  logic [N-1:0] pend_d = '0;
  logic         pend_s = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend <= 1'b0;
    end else begin
      if (pend && (!bus.in_valid || bus.in_data !== pend_d || bus.in_sel !== pend_s)) begin
        n_proto <= n_proto + 1;
      end
      pend   <= bus.in_valid && !bus.in_ready;
      pend_d <= bus.in_data;
      pend_s <= bus.in_sel;
    end
  end

  logic ir;
  logic [N-1:0] x0, x1, mx;
  logic s;
  int   ec;

  initial begin
    //            v  s  d     r0 r1 clr  ir z0    v0 z1    v1 c0 c1
    // alternating stream, both readies high
    tbl[0]  = mk(1, 0, 2'b01, 1, 1, 0,   1, 2'b01, 1, 2'b00, 0, 1, 0);
    tbl[1]  = mk(1, 1, 2'b10, 1, 1, 0,   1, 2'b01, 0, 2'b10, 1, 1, 1);
    tbl[2]  = mk(1, 0, 2'b11, 1, 1, 0,   1, 2'b11, 1, 2'b10, 0, 2, 1);
    tbl[3]  = mk(0, 0, 2'b11, 1, 1, 0,   1, 2'b11, 0, 2'b10, 0, 2, 1);
    // back-pressure on channel 1, then release with same-cycle drain and refill
    tbl[4]  = mk(1, 1, 2'b01, 1, 0, 0,   1, 2'b11, 0, 2'b01, 1, 2, 2);
    tbl[5]  = mk(1, 1, 2'b11, 1, 0, 0,   0, 2'b11, 0, 2'b01, 1, 2, 2);
    tbl[6]  = mk(1, 1, 2'b11, 1, 1, 0,   1, 2'b11, 0, 2'b11, 1, 2, 3);
    tbl[7]  = mk(0, 1, 2'b11, 1, 1, 0,   1, 2'b11, 0, 2'b11, 0, 2, 3);
    // stalled channel 1 does not block channel 0; in_ready independent of in_valid
    tbl[8]  = mk(1, 1, 2'b10, 1, 0, 0,   1, 2'b11, 0, 2'b10, 1, 2, 4);
    tbl[9]  = mk(1, 0, 2'b01, 0, 0, 0,   1, 2'b01, 1, 2'b10, 1, 3, 4);
    tbl[10] = mk(0, 0, 2'b01, 1, 0, 0,   1, 2'b01, 0, 2'b10, 1, 3, 4);
    tbl[11] = mk(0, 1, 2'b01, 0, 0, 0,   0, 2'b01, 0, 2'b10, 1, 3, 4);
    tbl[12] = mk(0, 1, 2'b01, 0, 1, 0,   1, 2'b01, 0, 2'b10, 0, 3, 4);
    // back-to-back words on channel 0 with consumer always ready: no bubbles
    tbl[13] = mk(1, 0, 2'b00, 1, 1, 0,   1, 2'b00, 1, 2'b10, 0, 4, 4);
    tbl[14] = mk(1, 0, 2'b01, 1, 1, 0,   1, 2'b01, 1, 2'b10, 0, 5, 4);
    tbl[15] = mk(1, 0, 2'b10, 1, 1, 0,   1, 2'b10, 1, 2'b10, 0, 6, 4);
    tbl[16] = mk(1, 0, 2'b11, 1, 1, 0,   1, 2'b11, 1, 2'b10, 0, 7, 4);
    tbl[17] = mk(0, 0, 2'b11, 1, 1, 0,   1, 2'b11, 0, 2'b10, 0, 7, 4);
    // counter clear
    tbl[18] = mk(0, 0, 2'b11, 1, 1, 1,   1, 2'b11, 0, 2'b10, 0, 0, 0);

    // Reset state, checked while rst_n is still low
    drive(0, 0, 2'b00, 0, 0, 0);
    #1;
    check("reset_state",
          {17'd0, bus.in_ready, bus.z0, bus.z0_valid, bus.z1, bus.z1_valid, bus.cnt0, bus.cnt1},
          {17'd0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0, 4'd0});
    #7;
    rst_n = 1'b1;
    next_edge();

    // Table-driven cycles
    for (int i = 0; i < NROWS; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r0, tbl[i].r1, tbl[i].clr);
      @(negedge clk);
      ir = bus.in_ready;
      next_edge();
      check($sformatf("row%0d", i),
            {17'd0, ir, bus.z0, bus.z0_valid, bus.z1, bus.z1_valid, bus.cnt0, bus.cnt1},
            {17'd0, tbl[i].e_ir, tbl[i].e_z0, tbl[i].e_v0, tbl[i].e_z1, tbl[i].e_v1,
             tbl[i].e_c0, tbl[i].e_c1});
    end

    // Saturation: 17 accepts to channel 1 from a cleared counter
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, N'(i), 1, 1, 0);
      next_edge();
      ec = (i + 1 > 15) ? 15 : i + 1;
      check($sformatf("sat%0d", i),
            {25'd0, bus.z1, bus.z1_valid, bus.cnt1},
            {25'd0, N'(i), 1'b1, CNT_W'(ec)});
    end
    drive(0, 1, 2'b00, 1, 1, 0);
    next_edge();
    check("sat_hold", {28'd0, bus.cnt1}, {28'd0, 4'd15});
    // Clear together with an accept: clear wins, word still loads
    drive(1, 1, 2'b01, 1, 1, 1);
    next_edge();
    check("clr_vs_inc", {21'd0, bus.z1, bus.z1_valid, bus.cnt1, bus.cnt0},
          {21'd0, 2'b01, 1'b1, 4'd0, 4'd0});

    // Asynchronous reset mid-cycle with both slots full
    drive(0, 0, 2'b00, 1, 1, 0);
    next_edge();
    drive(1, 0, 2'b10, 0, 0, 0);
    next_edge();
    drive(1, 1, 2'b11, 0, 0, 0);
    next_edge();
    drive(0, 1, 2'b11, 0, 0, 0);
    check("pre_reset", {18'd0, bus.z0, bus.z0_valid, bus.z1, bus.z1_valid, bus.cnt0, bus.cnt1},
          {18'd0, 2'b10, 1'b1, 2'b11, 1'b1, 4'd1, 4'd1});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {18'd0, bus.z0, bus.z0_valid, bus.z1, bus.z1_valid, bus.cnt0, bus.cnt1},
          32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    next_edge();
    check("post_reset", {18'd0, bus.z0, bus.z0_valid, bus.z1, bus.z1_valid, bus.cnt0, bus.cnt1},
          32'd0);

    // Loopback: a 2-input mux model feeds in_data, select follows the mux select
    for (int k = 0; k < 32; k++) begin
      s  = k[4];
      x0 = k[3:2];
      x1 = k[1:0];
      mx = s ? x1 : x0;
      drive(1, s, mx, 1, 1, 0);
      next_edge();
      if (s) begin
        check($sformatf("loop%0d", k), {29'd0, bus.z1_valid, bus.z1}, {29'd0, 1'b1, x1});
      end else begin
        check($sformatf("loop%0d", k), {29'd0, bus.z0_valid, bus.z0}, {29'd0, 1'b1, x0});
      end
    end
    drive(0, 0, 2'b00, 1, 1, 0);
    next_edge();

    check("sender_hold_violations", n_proto, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
